// File: rtl/rijndael_pkg.sv
// Shared types and elaboration-time helpers for the Rijndael cipher blocks.
package rijndael_pkg;

  // Round-controller state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  // Number of rounds for a given block and key size (in 32-bit words).
  function automatic int unsigned nr(input int unsigned nb, input int unsigned nk);
    return ((nb > nk) ? nb : nk) + 32'd6;
  endfunction

  // Rijndael defines block and key sizes of 4, 6 or 8 words only.
  function automatic bit legal_size(input int unsigned n);
    return (n == 32'd4) || (n == 32'd6) || (n == 32'd8);
  endfunction

endpackage

// File: rtl/rijndael_round_ctrl.sv
// Sequences one Rijndael block: key capture, keyschedule reload, NR+1 round-key
// applications, then a held result handshake. One block in flight at a time.
module rijndael_round_ctrl
  import rijndael_pkg::*;
#(
  parameter  int unsigned NB = 4,
  parameter  int unsigned NK = 4,
  localparam int unsigned NR = nr(NB, NK),
  localparam int unsigned RW = $clog2(NR + 1),
  localparam int unsigned KW = 32 * NK
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [KW-1:0] key_i,
  input  logic          flush_i,
  output logic [KW-1:0] key_o,
  output logic          ks_rst_no,
  output logic          ks_en_o,
  output logic          dp_load_o,
  output logic          dp_en_o,
  output logic          dp_last_o,
  output logic [RW-1:0] round_o,
  output logic          out_valid_o,
  input  logic          out_ready_i
);

  if (!legal_size(NB) || !legal_size(NK)) begin : g_bad_size
    $error("rijndael_round_ctrl: NB and NK must each be 4, 6 or 8");
  end

  ctrl_state_e   state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [KW-1:0] key_q, key_d;
  logic          in_ready_q, in_ready_d;
  logic          ks_rst_n_q, ks_rst_n_d;
  logic          ks_en_q, ks_en_d;
  logic          dp_load_q, dp_load_d;
  logic          dp_en_q, dp_en_d;
  logic          dp_last_q, dp_last_d;
  logic          out_valid_q, out_valid_d;

  // Next state, round counter and key capture; outputs decoded from the next
  // state so the registered outputs line up with the state they describe.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    key_d   = key_q;

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          key_d   = key_i;
          state_d = LOAD;
        end
      end
      LOAD: begin
        round_d = '0;
        state_d = ROUND;
      end
      ROUND: begin
        if (round_q == RW'(NR)) begin
          state_d = DONE;
        end else begin
          round_d = round_q + RW'(1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          round_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        round_d = '0;
        state_d = IDLE;
      end
    endcase

    // Abort wins over accept and over the result handshake.
    if (flush_i) begin
      key_d   = key_q;
      round_d = '0;
      state_d = IDLE;
    end

    in_ready_d  = (state_d == IDLE);
    ks_rst_n_d  = (state_d == ROUND) || (state_d == DONE);
    dp_load_d   = (state_d == ROUND) && (round_d == '0);
    dp_en_d     = (state_d == ROUND) && (round_d != '0);
    dp_last_d   = (state_d == ROUND) && (round_d == RW'(NR));
    ks_en_d     = (state_d == ROUND) && (round_d != RW'(NR));
    out_valid_d = (state_d == DONE);
  end

  // State, counter, key and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      round_q     <= '0;
      key_q       <= '0;
      in_ready_q  <= 1'b0;
      ks_rst_n_q  <= 1'b0;
      ks_en_q     <= 1'b0;
      dp_load_q   <= 1'b0;
      dp_en_q     <= 1'b0;
      dp_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      key_q       <= key_d;
      in_ready_q  <= in_ready_d;
      ks_rst_n_q  <= ks_rst_n_d;
      ks_en_q     <= ks_en_d;
      dp_load_q   <= dp_load_d;
      dp_en_q     <= dp_en_d;
      dp_last_q   <= dp_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign key_o       = key_q;
  assign ks_rst_no   = ks_rst_n_q;
  assign ks_en_o     = ks_en_q;
  assign dp_load_o   = dp_load_q;
  assign dp_en_o     = dp_en_q;
  assign dp_last_o   = dp_last_q;
  assign round_o     = round_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: doc/rijndael_round_ctrl.md
Name: rijndael_round_ctrl

Overview:
Control FSM that sequences one Rijndael block operation over the round datapath and the rijndael_keyschedule instance. It accepts a key via a valid/ready handshake and registers it. It reloads the key schedule, then steps the datapath and key schedule through NR+1 round-key applications. It presents a done handshake with output backpressure and processes one block at a time.

Parameters:
NB, 4, block size in 32-bit words; legal values are 4, 6 and 8.
NK, 4, key size in 32-bit words; legal values are 4, 6 and 8.
NR, derived localparam, number of rounds: max(NB,NK)+6. It is not overridable.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
in_valid_i  in  1  start request; key_i is valid
in_ready_o  out  1  controller can accept a request
key_i  in  32*NK  cipher key
flush_i  in  1  synchronous abort
key_o  out  32*NK  registered key, drives keyschedule key_i
ks_rst_no  out  1  registered active-low reload, drives keyschedule rst_ni
ks_en_o  out  1  keyschedule enable_i
dp_load_o  out  1  datapath: load input block and apply round key 0
dp_en_o  out  1  datapath: perform round round_o
dp_last_o  out  1  datapath: final round, with MixColumns skipped
round_o  out  $clog2(NR+1)  current round index
out_valid_o  out  1  result in datapath is final
out_ready_i  in  1  consumer accepts the result

Behaviour:
- Reset values: all outputs 0 (ks_rst_no=0, so the keyschedule is held in reload), key_o=0, round_o=0, state IDLE.
- States:
  - IDLE: in_ready_o=1. Accept occurs when in_valid_i is high: key_o<=key_i, go to LOAD.
  - LOAD: exactly 1 cycle, with ks_rst_no still 0 so the keyschedule samples the stable key_o. Set ks_rst_no<=1, round_o<=0, go to ROUND.
  - ROUND: one cycle per round index r=0..NR.
    - r=0: dp_load_o=1.
    - r=1..NR: dp_en_o=1.
    - r=NR: dp_last_o=1.
    - ks_en_o=1 for r=0..NR-1 and 0 at r=NR.
    - round_o increments each cycle. After r=NR, go to DONE.
  - DONE: out_valid_o=1 and held, with datapath and keyschedule idle. When out_ready_i is high, go to IDLE and set ks_rst_no<=0.
- Outputs:
  - ks_rst_no is a flop output with no combinational path from inputs. It is 0 in IDLE/LOAD and 1 in ROUND/DONE.
  - dp_*, ks_en_o, out_valid_o and in_ready_o are decoded from state/round_o only (Moore).
- Latency: if the accept edge is cycle 0, then LOAD is cycle 1 and ROUND r spans cycle r+2. out_valid_o first rises in cycle NR+3. For NB=NK=4 this is cycle 13.
- Throughput: no overlap. A new request is accepted only in IDLE, at the earliest one cycle after the DONE handshake.
- in_valid_i outside IDLE is ignored, and key_o is unchanged.
- flush_i in any state: next state IDLE, round_o<=0, ks_rst_no<=0, no out_valid_o. flush_i has priority over accept and over the DONE handshake in the same cycle.
- rst_i mid-operation: immediate return to reset values. No partial result is signalled.
- round_o never exceeds NR and does not wrap. The counter saturates by leaving ROUND.
- Parameter check: an elaboration-time $error fires if NB or NK is not in {4,6,8}.

Decomposition:
- Shared rijndael_pkg holds:
  - function nr(nb,nk) returning max(nb,nk)+6
  - state enum ctrl_state_e {IDLE, LOAD, ROUND, DONE}, 2 bits
  - legal-size check function
- No sub-module: the FSM and round counter fit in a single module (about 150 lines).
- The top-level cipher instantiates this block beside rijndael_keyschedule and the round datapath.

Test Plan:
1. NB=NK=4, key 2b7e1516_28aed2a6_abf71588_09cf4f3c, in_valid for 1 cycle, out_ready=1 -> key_o matches; dp_load at cycle 2; dp_en at cycles 3..12; dp_last only at cycle 12; ks_en count 10; out_valid for 1 cycle at cycle 13.
2. NB=4, NK=8 (NR=14) and NB=8, NK=6 (NR=14) -> out_valid at cycle 17, ks_en count 14, round_o sequence 0..14, no wrap.
3. out_ready=0 for 5 cycles in DONE -> out_valid held 5+1 cycles; in_ready=0 throughout; a second in_valid is ignored and key_o is unchanged.
4. flush_i at ROUND r=5 together with out_ready -> next cycle IDLE, in_ready=1, ks_rst_no=0, no out_valid pulse; a following request completes normally.
5. rst_i asserted at ROUND r=3 -> all outputs 0 asynchronously, before the next clock edge; after release, IDLE with in_ready=1.
6. Back-to-back requests with in_valid held high -> second accept one cycle after the DONE handshake; ks_rst_no low for exactly 2 cycles (IDLE+LOAD) between blocks.
